// File: rtl/add_seq_multiword.sv
// add_seq_multiword: splits a wide addition into LSW-first word passes through a registered adder,
// chaining each pass's carry-out into the next pass.
module add_seq_multiword #(
    parameter int W      = 16,
    parameter int NWORDS = 4,
    parameter int LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [W*NWORDS-1:0]   a,
    input  logic [W*NWORDS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [W*NWORDS-1:0]   result,
    output logic                  cout,
    output logic [W-1:0]          add_in1,
    output logic [W-1:0]          add_in2,
    output logic                  add_cin,
    input  logic [W-1:0]          add_sum,
    input  logic                  add_cout
);
    localparam int IW = NWORDS > 1 ? $clog2(NWORDS) : 1;
    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state, next;
    logic [W*NWORDS-1:0] a_r, b_r;
    logic [IW-1:0]       idx;
    logic [CW-1:0]       cnt;
    logic                last_beat, last_word;

    assign last_beat = state == WAIT && cnt == CW'(LAT - 1);
    assign last_word = idx == IW'(NWORDS - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? ISSUE : IDLE;
            ISSUE:   next = WAIT;
            WAIT:    next = last_beat ? (last_word ? DONE : ISSUE) : WAIT;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        busy = state == ISSUE || state == WAIT;
        done = state == DONE;
    end

    // Operand registers shift down one word per pass, so word 0 always feeds the adder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            idx     <= '0;
            cnt     <= '0;
            result  <= '0;
            cout    <= 1'b0;
            add_in1 <= '0;
            add_in2 <= '0;
            add_cin <= 1'b0;
        end else if (state == IDLE && start) begin
            a_r     <= a >> W;
            b_r     <= b >> W;
            add_in1 <= a[W-1:0];
            add_in2 <= b[W-1:0];
            add_cin <= cin;
            idx     <= '0;
            result  <= '0;
            cout    <= 1'b0;
        end else if (state == ISSUE) begin
            cnt <= '0;
        end else if (state == WAIT) begin
            cnt <= cnt + CW'(1);
            if (last_beat) begin
                result[int'(idx)*W +: W] <= add_sum;
                if (last_word) begin
                    cout <= add_cout;
                end else begin
                    idx     <= idx + IW'(1);
                    add_in1 <= a_r[W-1:0];
                    add_in2 <= b_r[W-1:0];
                    add_cin <= add_cout;
                    a_r     <= a_r >> W;
                    b_r     <= b_r >> W;
                end
            end
        end
    end
endmodule
